dram_word_master: RTL

- Bus initiator for the byte-wide DRAM on the motherboard bus.
- Accepts one CPU-side load/store request of byte, half or word size.
- Issues one DRAM byte access per clock, little-endian, and returns a single response.
- Sits between the core's load/store unit and the DRAM bus port.

---
 rtl/dram_word_master.sv | 132 +++++++++++++
 1 files changed

// File: rtl/dram_word_master.sv
// Byte-serial DRAM initiator: turns one byte/half/word load or store into 1, 2 or 4
// little-endian byte accesses. Define ALIGN_CHECK_EN to reject misaligned half/word requests.
module dram_word_master #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_we,
  input  logic [7:0]            mem_rdata,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  we_q;
  logic [1:0]            last_q;
  logic [1:0]            k_q;
  logic [1:0]            k_nxt;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [31:0]           wdata_q;
  logic [31:0]           buf_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [7:0]            mem_wdata_q;
  logic                  mem_we_q;
  logic [1:0]            size_last;
  logic                  reject;

  // Handshake: a request transfers on a posedge where req_valid && req_ready; the
  // request fields are sampled on that edge only. resp_valid is a one-cycle pulse
  // with no back-pressure.
  assign size_last = (req_size == 2'd0) ? 2'd0 : (req_size == 2'd1) ? 2'd1 : 2'd3;
  assign k_nxt     = k_q + 2'd1;

`ifdef ALIGN_CHECK_EN
  assign reject = ((req_size == 2'd1) && req_addr[0]) ||
                  (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign reject = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = reject ? DONE : XFER;
      XFER:    if (k_q == last_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // DRAM-side outputs are registered one cycle ahead so they hold steady across the
  // negedge where the DRAM commits a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      last_q      <= 2'd0;
      k_q         <= 2'd0;
      base_q      <= '0;
      wdata_q     <= 32'h0;
      buf_q       <= 32'h0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
      mem_we_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            last_q  <= size_last;
            base_q  <= req_addr;
            wdata_q <= req_wdata;
            k_q     <= 2'd0;
            buf_q   <= 32'h0;
            err_q   <= reject;
            if (!reject) begin
              mem_addr_q  <= req_addr;
              mem_we_q    <= req_we;
              mem_wdata_q <= req_we ? req_wdata[7:0] : 8'h00;
            end
          end
        end
        XFER: begin
          if (!we_q) buf_q[{k_q, 3'b000} +: 8] <= mem_rdata;
          k_q <= k_nxt;
          if (k_q == last_q) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            mem_we_q    <= 1'b0;
          end else begin
            mem_addr_q  <= base_q + {{(ADDR_WIDTH-2){1'b0}}, k_nxt};
            mem_wdata_q <= we_q ? wdata_q[{k_nxt, 3'b000} +: 8] : 8'h00;
            mem_we_q    <= we_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign resp_rdata = (state_q == DONE) ? buf_q : 32'h0;
  assign resp_err   = (state_q == DONE) && err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign dbg_state  = state_q;

endmodule
